mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the 5-stage MIPS pipeline using a req/ack handshake to a multi-cycle data memory.
- Freezes the pipeline while an access is outstanding.
- Inserts a bubble into the MEM/WB register during the freeze by gating RegWriteM.
- Supplies the read data that the MEM/WB register latches as ReadDataW.

Parameters:
- TIMEOUT, 15, number of REQ cycles without mem_ack before the access is aborted (used only with MEM_TIMEOUT_EN); legal range 1..255.

Ports:
- clock  input  1  pipeline clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset
- MemReadM  input  1  load in MEM stage
- MemWriteM  input  1  store in MEM stage
- RegWriteM  input  1  register-write control from EX/MEM
- ALUOutM  input  32  access address
- WriteDataM  input  32  store data
- mem_ack  input  1  memory completion; sampled only in REQ
- mem_rdata  input  32  memory read data; valid when mem_ack=1
- mem_req  output  1  registered request to memory
- mem_we  output  1  registered write enable (1 = store)
- mem_addr  output  32  registered address
- mem_wdata  output  32  registered store data
- StallPipe  output  1  holds PC, IF/ID, ID/EX and EX/MEM
- RegWriteMOut  output  1  gated RegWriteM toward MEM/WB
- RDOut  output  32  read data toward MEM/WB (RD input)
- mem_err  output  1  one-cycle pulse on aborted access

Behaviour:
- Async reset (reset=0):
  - state=IDLE.
  - mem_req, mem_we, mem_err, RDOut-capture register, mem_addr and mem_wdata all cleared to 0.
  - StallPipe forced to 0; RegWriteMOut forced to 0.
  - Takes effect immediately, including mid-access: mem_req drops at once and the access is abandoned with no retry.
- Access present: acc = MemReadM | MemWriteM.
- Read and write both set: treated as a write (mem_we=1); memory is never read.
- IDLE, acc=0:
  - StallPipe=0; RegWriteMOut=RegWriteM; RDOut=0.
  - Stays in IDLE.
- IDLE, acc=1:
  - StallPipe=1; RegWriteMOut=0.
  - Next edge: latch ALUOutM→mem_addr, WriteDataM→mem_wdata, MemWriteM→mem_we; set mem_req=1; clear timeout counter; go to REQ.
- REQ:
  - StallPipe=1; RegWriteMOut=0; mem_req held at 1; address and data held stable.
  - mem_ack=1 at an edge:
    - Capture mem_rdata into the capture register for reads; capture 0 for writes.
    - mem_req←0; go to DONE.
  - mem_ack=0: counter increments.
- DONE (exactly one cycle):
  - StallPipe=0; RegWriteMOut=RegWriteM; RDOut=capture register.
  - The pipeline advances at the closing edge; the next state is always IDLE.
  - A following access then enters M and is detected in IDLE, so back-to-back accesses cost ≥3 cycles each.
- Latency: an access holds M for 3 cycles minimum (IDLE, REQ with immediate ack, DONE), plus one cycle per REQ cycle without ack.
- mem_ack outside REQ is ignored; it causes no state change and no capture.
- StallPipe, RegWriteMOut and RDOut are combinational from state and the M-stage inputs; all memory-side outputs are registered.
- Timeout counter: 8 bits, saturating.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - In REQ, when the counter reaches TIMEOUT with mem_ack=0, the next edge sets mem_req←0, capture←0, and goes to DONE.
  - mem_err=1 for that DONE cycle only.
  - The load writes 0 to the register file.
- Not defined:
  - REQ waits indefinitely for mem_ack.
  - No counter logic is built; mem_err is tied to 0.

Test Plan:
- Reset sequence: reset low mid-REQ → mem_req=0 and StallPipe=0 the same cycle; after release, state IDLE and all outputs 0.
- Load with immediate ack: MemReadM=1, RegWriteM=1, ALUOutM=0x0000_0040, ack on first REQ cycle with mem_rdata=0x1234_5678 → StallPipe=1 for 2 cycles; mem_addr=0x40; DONE cycle RDOut=0x1234_5678, RegWriteMOut=1.
- Store with 3-cycle ack delay: MemWriteM=1, ALUOutM=0x80, WriteDataM=0xCAFE_F00D → mem_we=1, mem_wdata=0xCAFE_F00D; StallPipe high 5 cycles; RegWriteMOut=0 while stalled; RDOut=0 in DONE.
- Back-to-back loads: two loads, ack immediate each → each stalls 2 cycles; second load's mem_addr latched only after the first's DONE; no duplicate request.
- Spurious ack and non-memory op: mem_ack=1 in IDLE with an ALU instruction in M → StallPipe=0, RegWriteMOut follows RegWriteM, no mem_req.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT=4): load, mem_ack never asserted → mem_req drops after 5 REQ cycles; mem_err pulses 1 cycle; RDOut=0; pipeline resumes.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer for the MIPS MEM stage: req/ack to a multi-cycle memory, freezes the pipe while busy.
// Optional abort-on-timeout logic is built only when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        RegWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        StallPipe,
  output logic        RegWriteMOut,
  output logic [31:0] RDOut,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rdata_q;
  logic        acc;
  logic        busy;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  assign acc = MemReadM | MemWriteM;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       mem_err_q;
  logic       timeout;

  assign cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign timeout = (cnt_q == 8'(TIMEOUT));
  assign mem_err = mem_err_q;
`else
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      mem_err_q   <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      mem_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (acc) begin
            mem_addr_q  <= ALUOutM;
            mem_wdata_q <= WriteDataM;
            mem_we_q    <= MemWriteM;
            mem_req_q   <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            // Stores hand zero to MEM/WB so a stray RegWrite cannot leak bus data.
            rdata_q   <= mem_we_q ? 32'd0 : mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout) begin
            rdata_q   <= '0;
            mem_req_q <= 1'b0;
            mem_err_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Reset gating makes the freeze and the write-enable drop the instant reset asserts.
  assign busy         = (state_q == REQ) || ((state_q == IDLE) && acc);
  assign StallPipe    = reset & busy;
  assign RegWriteMOut = reset & ~busy & RegWriteM;
  assign RDOut        = (state_q == DONE) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: IDLE vector table plus multi-cycle access sequences.
module tb_mem_access_ctrl;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM, RegWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        StallPipe, RegWriteMOut;
  logic [31:0] RDOut;
  logic        mem_err;

  int total_cnt = 0;
  int pass_cnt  = 0;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .StallPipe(StallPipe), .RegWriteMOut(RegWriteMOut), .RDOut(RDOut), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic clear_inputs();
    MemReadM = 0; MemWriteM = 0; RegWriteM = 0; mem_ack = 0;
  endtask

  // One full access; starts at a negedge in IDLE, or in the DONE cycle of a prior access when after_done=1.
  task automatic access(input string nm, input logic rd, input logic wr, input logic rw,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                        input int delay, input bit after_done);
    int          stall;
    bit          rw_bad;
    bit          hold_bad;
    logic [31:0] prev_addr;
    logic [31:0] exp_rd;
    stall = 0; rw_bad = 0; hold_bad = 0;
    prev_addr = mem_addr;
    exp_rd = wr ? 32'd0 : rdat;
    MemReadM = rd; MemWriteM = wr; RegWriteM = rw;
    ALUOutM = addr; WriteDataM = wd; mem_rdata = rdat; mem_ack = 0;
    if (after_done) @(negedge clock);
    #1;
    chk({nm, "_idle_no_req"}, mem_req, 0);
    chk({nm, "_idle_addr_unchanged"}, mem_addr, prev_addr);
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (StallPipe !== 1'b1) break;
      stall++;
      if (RegWriteMOut !== 1'b0) rw_bad = 1;
      if (cyc >= 1 && (mem_req !== 1'b1 || mem_addr !== addr)) hold_bad = 1;
      if (cyc == 1) begin
        chk({nm, "_req"}, mem_req, 1);
        chk({nm, "_addr"}, mem_addr, addr);
        chk({nm, "_we"}, mem_we, wr);
        chk({nm, "_wdata"}, mem_wdata, wd);
      end
      mem_ack = (cyc == 1 + delay);
      @(negedge clock);
      #1;
    end
    mem_ack = 0;
    chk({nm, "_stall_cycles"}, stall, 2 + delay);
    chk({nm, "_rw_gated"}, rw_bad, 0);
    chk({nm, "_req_hold"}, hold_bad, 0);
    chk({nm, "_done_rdout"}, RDOut, exp_rd);
    chk({nm, "_done_rwout"}, RegWriteMOut, rw);
    chk({nm, "_done_req_low"}, mem_req, 0);
    chk({nm, "_done_err"}, mem_err, 0);
  endtask

  typedef struct {
    logic rd, wr, rw, ack;
    logic exp_stall, exp_rw;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{rd:0, wr:0, rw:0, ack:0, exp_stall:0, exp_rw:0};
    vecs[1] = '{rd:0, wr:0, rw:1, ack:0, exp_stall:0, exp_rw:1};
    vecs[2] = '{rd:0, wr:0, rw:1, ack:1, exp_stall:0, exp_rw:1};
    vecs[3] = '{rd:1, wr:0, rw:1, ack:0, exp_stall:1, exp_rw:0};
    vecs[4] = '{rd:0, wr:1, rw:1, ack:1, exp_stall:1, exp_rw:0};
    vecs[5] = '{rd:1, wr:1, rw:0, ack:0, exp_stall:1, exp_rw:0};

    reset = 0;
    clear_inputs();
    RegWriteM = 1;
    ALUOutM = 32'h0000_1000; WriteDataM = 32'h1111_1111; mem_rdata = 32'h2222_2222;
    #12;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_stall", StallPipe, 0);
    chk("rst_rwout", RegWriteMOut, 0);
    chk("rst_rdout", RDOut, 0);
    @(negedge clock);
    reset = 1;
    RegWriteM = 0;

    // IDLE-state combinational behaviour; accesses are withdrawn before the edge so state never leaves IDLE.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      MemReadM = vecs[i].rd; MemWriteM = vecs[i].wr;
      RegWriteM = vecs[i].rw; mem_ack = vecs[i].ack;
      #1;
      chk($sformatf("vec%0d_stall", i), StallPipe, vecs[i].exp_stall);
      chk($sformatf("vec%0d_rwout", i), RegWriteMOut, vecs[i].exp_rw);
      chk($sformatf("vec%0d_rdout", i), RDOut, 0);
      chk($sformatf("vec%0d_no_req", i), mem_req, 0);
      clear_inputs();
    end
    @(negedge clock);

    access("ld", 1, 0, 1, 32'h0000_0040, 32'h0, 32'h1234_5678, 0, 0);
    clear_inputs();
    @(negedge clock);

    access("st", 0, 1, 0, 32'h0000_0080, 32'hCAFE_F00D, 32'hDEAD_BEEF, 3, 0);
    clear_inputs();
    @(negedge clock);

    access("b2b1", 1, 0, 1, 32'h0000_0100, 32'h0, 32'hA5A5_A5A5, 0, 0);
    access("b2b2", 1, 0, 1, 32'h0000_0104, 32'h0, 32'h5A5A_5A5A, 0, 1);
    clear_inputs();
    @(negedge clock);
    #1;
    chk("b2b_no_dup_req", mem_req, 0);
    chk("b2b_idle_stall", StallPipe, 0);
    @(negedge clock);

    access("rdwr", 1, 1, 1, 32'h0000_00C0, 32'h1111_2222, 32'h3333_4444, 1, 0);
    clear_inputs();
    @(negedge clock);

`ifdef MEM_TIMEOUT_EN
    begin
      int n;
      n = 0;
      MemReadM = 1; RegWriteM = 1; ALUOutM = 32'h0000_0200; mem_rdata = 32'h7777_7777;
      @(negedge clock);
      #1;
      for (int c = 0; c < 100; c++) begin
        if (mem_req !== 1'b1) break;
        n++;
        @(negedge clock);
        #1;
      end
      chk("to_req_cycles", n, TO + 1);
      chk("to_err", mem_err, 1);
      chk("to_rdout", RDOut, 0);
      chk("to_stall", StallPipe, 0);
      chk("to_rwout", RegWriteMOut, 1);
      clear_inputs();
      @(negedge clock);
      #1;
      chk("to_err_pulse", mem_err, 0);
      @(negedge clock);
    end
`endif

    // Reset asserted mid-REQ abandons the access immediately.
    MemReadM = 1; RegWriteM = 1; ALUOutM = 32'h0000_0300; WriteDataM = 32'h0000_0055;
    @(negedge clock);
    #1;
    chk("mid_req_active", mem_req, 1);
    reset = 0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_stall", StallPipe, 0);
    chk("mid_rst_rwout", RegWriteMOut, 0);
    chk("mid_rst_addr", mem_addr, 0);
    clear_inputs();
    @(negedge clock);
    reset = 1;
    #1;
    chk("post_rst_stall", StallPipe, 0);
    chk("post_rst_req", mem_req, 0);
    chk("post_rst_we", mem_we, 0);
    chk("post_rst_wdata", mem_wdata, 0);
    chk("post_rst_rdout", RDOut, 0);
    chk("post_rst_err", mem_err, 0);
    @(negedge clock);
    access("recover", 1, 0, 1, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 1, 0);
    clear_inputs();
    @(negedge clock);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
